// File: rtl/median_filter_pkg.sv
// median_filter_pkg: shared limits, width helper, legality check and sample compare for the median window filter
package median_filter_pkg;

    localparam int MAX_WIN = 15;

    // Width of age tags and the fill counter for a given window length
    function automatic int age_w(input int win);
        return $clog2(win + 1);
    endfunction

    function automatic bit win_ok(input int win, input int dw);
        return win >= 3 && win <= MAX_WIN && win % 2 == 1 && dw >= 2 && dw <= 32;
    endfunction

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one magnitude compare serves both modes
    function automatic logic cmp_gt(input logic [31:0] a, input logic [31:0] b, input int dw, input bit sgn);
        logic [31:0] flip;
        flip = sgn ? 32'd1 << (dw - 1) : 32'd0;
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/median_sort_slot.sv
// median_sort_slot: one position of the sorted window, holding a sample value and its age tag
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous return to reset contents
//   upd                 : apply the evict/insert update this cycle
//   prev_*/cur_*/next_* : values and ages of the slot below, this slot and the slot above
//   new_val             : incoming sample
//   del_idx, ins_rank   : position of the evicted entry, rank of the new entry among survivors
//   val, age            : registered slot contents
module median_sort_slot
    import median_filter_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int DATA_WIDTH = 16,
    parameter int WIN        = 5,
    parameter int AW         = age_w(WIN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  upd,
    input  logic [DATA_WIDTH-1:0] prev_val,
    input  logic [AW-1:0]         prev_age,
    input  logic [DATA_WIDTH-1:0] cur_val,
    input  logic [AW-1:0]         cur_age,
    input  logic [DATA_WIDTH-1:0] next_val,
    input  logic [AW-1:0]         next_age,
    input  logic [DATA_WIDTH-1:0] new_val,
    input  logic [AW-1:0]         del_idx,
    input  logic [AW-1:0]         ins_rank,
    output logic [DATA_WIDTH-1:0] val,
    output logic [AW-1:0]         age
);

    localparam logic [AW-1:0] K      = AW'(IDX);
    localparam logic [AW-1:0] NEWEST = AW'(WIN - 1);

    logic [DATA_WIDTH-1:0] shift_val, nxt_val;
    logic [AW-1:0]         shift_age, nxt_age;

    // Below the insertion rank a slot takes the survivor at its own index, which sits one
    // place higher once past the gap; above it the slot takes the survivor one index lower
    always_comb begin
        shift_val = (K < ins_rank) ? ((K < del_idx) ? cur_val : next_val) : ((K <= del_idx) ? prev_val : cur_val);
        shift_age = (K < ins_rank) ? ((K < del_idx) ? cur_age : next_age) : ((K <= del_idx) ? prev_age : cur_age);
        nxt_val   = (K == ins_rank) ? new_val : shift_val;
        nxt_age   = (K == ins_rank) ? NEWEST : shift_age - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
            age <= K;
        end else if (flush) begin
            val <= '0;
            age <= K;
        end else if (upd) begin
            val <= nxt_val;
            age <= nxt_age;
        end
    end

endmodule

// File: rtl/median_window_filter.sv
// median_window_filter: running median over the last WIN samples, kept as an age-tagged sorted array
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   flush_i                : synchronous window clear
//   src_vld_i, src_data_i  : input sample strobe and value
//   mid_vld_o, mid_data_o  : median strobe and value, two clocks after the sample
//   win_full_o             : window holds WIN real samples since reset/flush
module median_window_filter
    import median_filter_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int WIN         = 5,
    parameter bit SIGNED_MODE = 0,
    parameter bit PRIME_MODE  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  src_vld_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  mid_vld_o,
    output logic [DATA_WIDTH-1:0] mid_data_o,
    output logic                  win_full_o
);

    localparam int            AW   = age_w(WIN);
    localparam int            MID  = (WIN - 1) / 2;
    localparam logic [AW-1:0] FULL = AW'(WIN);

    if (!win_ok(WIN, DATA_WIDTH)) begin : g_bad_param
        $error("median_window_filter: WIN must be odd in 3..%0d and DATA_WIDTH in 2..32", MAX_WIN);
    end

    logic                  s1_vld, s2_vld, emit;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [AW-1:0]         cnt, del_idx, ins_rank;
    logic [WIN-1:0]        gt;
    logic [DATA_WIDTH-1:0] val [WIN];
    logic [AW-1:0]         age [WIN];

    // The oldest entry always carries age 0; the new sample ranks above every
    // surviving entry it is strictly greater than
    always_comb begin
        gt       = '0;
        del_idx  = '0;
        ins_rank = '0;
        for (int k = 0; k < WIN; k++) begin
            gt[k] = cmp_gt(32'(s1_data), 32'(val[k]), DATA_WIDTH, SIGNED_MODE);
            if (age[k] == '0) del_idx = AW'(k);
        end
        for (int k = 0; k < WIN; k++)
            if (gt[k] && AW'(k) != del_idx) ins_rank = ins_rank + 1'b1;
    end

    for (genvar k = 0; k < WIN; k++) begin : g_slot
        median_sort_slot #(
            .IDX       (k),
            .DATA_WIDTH(DATA_WIDTH),
            .WIN       (WIN),
            .AW        (AW)
        ) u_slot (
            .clk     (clk_i),
            .rst     (rst_i),
            .flush   (flush_i),
            .upd     (s1_vld),
            .prev_val(val[(k == 0) ? 0 : k - 1]),
            .prev_age(age[(k == 0) ? 0 : k - 1]),
            .cur_val (val[k]),
            .cur_age (age[k]),
            .next_val(val[(k == WIN - 1) ? k : k + 1]),
            .next_age(age[(k == WIN - 1) ? k : k + 1]),
            .new_val (s1_data),
            .del_idx (del_idx),
            .ins_rank(ins_rank),
            .val     (val[k]),
            .age     (age[k])
        );
    end

    // cnt already reflects the sample now in S3, so priming releases on the filling sample
    assign emit       = s2_vld && (!PRIME_MODE || cnt == FULL);
    assign win_full_o = cnt == FULL;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld     <= 1'b0;
            s1_data    <= '0;
            s2_vld     <= 1'b0;
            cnt        <= '0;
            mid_vld_o  <= 1'b0;
            mid_data_o <= '0;
        end else begin
            s1_vld    <= src_vld_i;
            s1_data   <= src_data_i;
            s2_vld    <= s1_vld && !flush_i;
            cnt       <= flush_i ? '0 : (s1_vld && cnt != FULL) ? cnt + 1'b1 : cnt;
            mid_vld_o <= emit;
            if (emit) mid_data_o <= val[MID];
        end
    end

endmodule

// File: tb/tb_median_window_filter.sv
// tb_median_window_filter: directed table and sequence checks of the median window filter
module tb_median_window_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] data = '0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic [4:0]  mv, wf;
    logic [15:0] md0, md1, md3, md4;
    logic [7:0]  md2;

    always #5 clk = ~clk;

    // 0: WIN5 primed, 1: WIN5 unprimed, 2: WIN3 signed 8-bit, 3: WIN7 primed, 4: WIN3 primed
    median_window_filter #(.WIN(5), .PRIME_MODE(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush && sel == 0), .src_vld_i(vld && sel == 0),
        .src_data_i(data), .mid_vld_o(mv[0]), .mid_data_o(md0), .win_full_o(wf[0]));
    median_window_filter #(.WIN(5), .PRIME_MODE(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush && sel == 1), .src_vld_i(vld && sel == 1),
        .src_data_i(data), .mid_vld_o(mv[1]), .mid_data_o(md1), .win_full_o(wf[1]));
    median_window_filter #(.DATA_WIDTH(8), .WIN(3), .SIGNED_MODE(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush && sel == 2), .src_vld_i(vld && sel == 2),
        .src_data_i(data[7:0]), .mid_vld_o(mv[2]), .mid_data_o(md2), .win_full_o(wf[2]));
    median_window_filter #(.WIN(7), .PRIME_MODE(1)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush && sel == 3), .src_vld_i(vld && sel == 3),
        .src_data_i(data), .mid_vld_o(mv[3]), .mid_data_o(md3), .win_full_o(wf[3]));
    median_window_filter #(.WIN(3), .PRIME_MODE(1)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush && sel == 4), .src_vld_i(vld && sel == 4),
        .src_data_i(data), .mid_vld_o(mv[4]), .mid_data_o(md4), .win_full_o(wf[4]));

    function automatic logic [15:0] mdof(input int i);
        return i == 0 ? md0 : i == 1 ? md1 : i == 2 ? {8'h00, md2} : i == 3 ? md3 : md4;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // The WIN=7 array must stay sorted with ages forming a permutation of 0..6
    always @(negedge clk) begin : inv
        logic [7:0] seen;
        logic       ok;
        if (!rst) begin
            seen = '0;
            ok   = 1'b1;
            for (int i = 0; i < 7; i++) begin
                seen[dut3.age[i]] = 1'b1;
                if (i > 0 && dut3.val[i] < dut3.val[i-1]) ok = 1'b0;
            end
            checks++;
            if (!ok || seen != 8'h7F) begin
                errors++;
                $display("FAIL dut3 invariant: sorted=%0b ages_seen=%b, expected sorted=1 ages_seen=01111111", ok, seen);
            end
        end
    end

    typedef struct {
        int          sel;
        logic        vld;
        logic [15:0] data;
        logic        ev;
        logic [15:0] ed;
        logic        ef;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int s, input bit vi, input int d, input bit ev, input int ed, input bit ef);
        vec_t r;
        r.sel  = s;
        r.vld  = vi;
        r.data = 16'(d);
        r.ev   = ev;
        r.ed   = 16'(ed);
        r.ef   = ef;
        tbl.push_back(r);
    endtask

    initial begin
        // WIN5 primed: 10,50,30,20,40,60 -> 30 then 40
        add(0, 1, 10, 0, 0, 0);  add(0, 1, 50, 0, 0, 0);  add(0, 1, 30, 0, 0, 0);
        add(0, 1, 20, 0, 0, 0);  add(0, 1, 40, 0, 0, 0);  add(0, 1, 60, 0, 0, 1);
        add(0, 0, 0, 1, 30, 1);  add(0, 0, 0, 1, 40, 1);  add(0, 0, 0, 0, 0, 1);
        // WIN5 unprimed: 7,9,8 -> 0,0,7
        add(1, 1, 7, 0, 0, 0);   add(1, 1, 9, 0, 0, 0);   add(1, 1, 8, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0);   add(1, 0, 0, 1, 7, 0);   add(1, 0, 0, 0, 0, 0);
        // WIN3 signed: -128,127,-1 -> 0,0,-1
        add(2, 1, 'h80, 0, 0, 0); add(2, 1, 'h7F, 0, 0, 0); add(2, 1, 'hFF, 1, 0, 0);
        add(2, 0, 0, 1, 0, 1);    add(2, 0, 0, 1, 'hFF, 1);  add(2, 0, 0, 0, 0, 1);
        // WIN7 primed: 5 x5, 3, 9, 5, 9, 9, 9 -> 5,5,5,5,9
        for (int i = 0; i < 5; i++) add(3, 1, 5, 0, 0, 0);
        add(3, 1, 3, 0, 0, 0);   add(3, 1, 9, 0, 0, 0);   add(3, 1, 5, 0, 0, 1);
        add(3, 1, 9, 1, 5, 1);   add(3, 1, 9, 1, 5, 1);   add(3, 1, 9, 1, 5, 1);
        add(3, 0, 0, 1, 5, 1);   add(3, 0, 0, 1, 9, 1);   add(3, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset dut%0d mid_vld", i), 16'(mv[i]), 16'd0);
            chk($sformatf("reset dut%0d win_full", i), 16'(wf[i]), 16'd0);
            chk($sformatf("reset dut%0d mid_data", i), mdof(i), 16'd0);
        end
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            sel  = tbl[i].sel;
            vld  = tbl[i].vld;
            data = tbl[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d dut%0d mid_vld", i, sel), 16'(mv[sel]), 16'(tbl[i].ev));
            chk($sformatf("row%0d dut%0d win_full", i, sel), 16'(wf[sel]), 16'(tbl[i].ef));
            if (tbl[i].ev) chk($sformatf("row%0d dut%0d mid_data", i, sel), mdof(sel), tbl[i].ed);
        end
        @(negedge clk) vld = 1'b0;

        // Async reset mid-burst on the full WIN5 primed window
        sel = 0;
        @(negedge clk) begin vld = 1'b1; data = 16'd11; end
        @(negedge clk) data = 16'd12;
        @(negedge clk) data = 16'd13;
        @(posedge clk);
        #1;
        chk("burst mid_vld", 16'(mv[0]), 16'd1);
        chk("burst mid_data", md0, 16'd30);
        #2 rst = 1'b1;
        #1;
        chk("async rst mid_vld", 16'(mv[0]), 16'd0);
        chk("async rst win_full", 16'(wf[0]), 16'd0);
        vld = 1'b0;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vld  = c < 5;
            data = 16'(c + 1);
            @(posedge clk);
            #1;
            chk($sformatf("post-rst c%0d mid_vld", c), 16'(mv[0]), 16'(c == 6));
            chk($sformatf("post-rst c%0d win_full", c), 16'(wf[0]), 16'(c >= 5));
            if (c == 6) chk("post-rst median", md0, 16'd3);
        end

        // Flush with a same-cycle sample on WIN3 primed: in-flight 2 still emits, then 150
        begin
            bit fv[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
            bit ff[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
            int fd[10] = '{1, 2, 3, 0, 100, 200, 150, 0, 0, 0};
            bit ev[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
            int ed[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 150, 0};
            bit ef[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
            sel = 4;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                vld   = fv[c];
                flush = ff[c];
                data  = 16'(fd[c]);
                @(posedge clk);
                #1;
                chk($sformatf("flush c%0d mid_vld", c), 16'(mv[4]), 16'(ev[c]));
                chk($sformatf("flush c%0d win_full", c), 16'(wf[4]), 16'(ef[c]));
                if (ev[c]) chk($sformatf("flush c%0d mid_data", c), md4, 16'(ed[c]));
            end
            @(negedge clk) begin vld = 1'b0; flush = 1'b0; end
            chk("flush hold mid_data", md4, 16'd150);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
